// File: rtl/mem_access_sched.sv
// mem_access_sched
// ----------------
// Sequences every access to the shared image/instruction memory. Two
// requesters compete for the single memory port:
//   - the instruction-fetch path (always reads), and
//   - the data path (reads or writes; its address comes from AR and its
//     write data from MBR).
// A round-robin arbiter picks one requester in IDLE. The FSM then walks
// IDLE -> ISSUE -> (WAIT) -> DONE -> IDLE and drives the memory strobes.
//
// Handshake (both requesters): req is raised and held until the matching
// *_done pulse. The block latches address, we and wdata at grant time, so
// later changes to req or the request fields have no effect on an access
// already granted. The requester drops req at the clock edge that ends its
// done cycle, or keeps it high to ask for another access. *_gnt is high from
// ISSUE through DONE for the owner.
//
// All outputs are registers. No combinational path runs from any input to
// any output.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   fetch_req/addr      fetch request and PC address
//   fetch_gnt/done      fetch owns memory / one-cycle completion pulse
//   data_req/we/addr/wdata  data request, direction, AR address, MBR data
//   data_gnt/done       data owns memory / one-cycle completion pulse
//   rdata               last captured read data, held until the next read
//   mem_addr/wdata/rd/wr  memory address, write data and strobes
//   mem_rdata           memory read data, valid MEM_LAT cycles after mem_rd
//   busy                high in any state other than IDLE
module mem_access_sched #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 2   // legal range 1..7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_done,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_gnt,
    output logic              data_done,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Read data is valid MEM_LAT cycles after the strobe. ISSUE is the
    // strobe cycle, so WAIT runs MEM_LAT cycles, and the counter starts at
    // MEM_LAT-1. It captures when the counter reads zero. With MEM_LAT=1
    // this still passes through a single WAIT cycle, so done always lands in
    // cycle 2+MEM_LAT.
    localparam logic [2:0] WAIT_INIT = 3'(MEM_LAT - 1);

    state_t      state;
    logic        owner_fetch;  // current/last owner; doubles as the round-robin pointer
    logic        acc_we;       // latched direction of the access in flight
    logic [2:0]  wait_cnt;

    logic              pick_fetch;
    logic              pick_we;
    logic [ADDR_W-1:0] pick_addr;

    // Round-robin: a tie goes to whoever was not granted last. Reset clears
    // owner_fetch, so fetch wins the first tie. A lone request always wins.
    always_comb begin
        pick_fetch = fetch_req && !(data_req && owner_fetch);
        pick_we    = pick_fetch ? 1'b0 : data_we;
        pick_addr  = pick_fetch ? fetch_addr : data_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner_fetch <= 1'b0;
            acc_we      <= 1'b0;
            wait_cnt    <= 3'd0;
            fetch_gnt   <= 1'b0;
            fetch_done  <= 1'b0;
            data_gnt    <= 1'b0;
            data_done   <= 1'b0;
            rdata       <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            busy        <= 1'b0;
        end else begin
            // Done outputs are single-cycle pulses, raised only on entry to DONE.
            fetch_done <= 1'b0;
            data_done  <= 1'b0;

            case (state)
                IDLE: begin
                    if (fetch_req || data_req) begin
                        // mem_addr itself is the latched address. It holds
                        // from ISSUE through DONE, so requester changes after
                        // the grant are ignored.
                        state       <= ISSUE;
                        owner_fetch <= pick_fetch;
                        acc_we      <= pick_we;
                        fetch_gnt   <= pick_fetch;
                        data_gnt    <= !pick_fetch;
                        busy        <= 1'b1;
                        mem_addr    <= pick_addr;
                        mem_rd      <= !pick_we;
                        mem_wr      <= pick_we;
                        mem_wdata   <= pick_we ? data_wdata : '0;
                    end
                end

                ISSUE: begin
                    mem_rd    <= 1'b0;
                    mem_wr    <= 1'b0;
                    mem_wdata <= '0;
                    if (acc_we) begin
                        // Writes complete on the strobe; rdata is untouched.
                        state      <= DONE;
                        fetch_done <= owner_fetch;
                        data_done  <= !owner_fetch;
                    end else begin
                        state    <= WAIT;
                        wait_cnt <= WAIT_INIT;
                    end
                end

                WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        rdata      <= mem_rdata;
                        state      <= DONE;
                        fetch_done <= owner_fetch;
                        data_done  <= !owner_fetch;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end

                DONE: begin
                    state     <= IDLE;
                    fetch_gnt <= 1'b0;
                    data_gnt  <= 1'b0;
                    busy      <= 1'b0;
                    mem_addr  <= '0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_sched.sv
// Directed testbench for mem_access_sched. Two instances share the request
// side: dut uses MEM_LAT=2 and dut_l1 uses MEM_LAT=1. Each instance has its
// own latency-accurate memory model. Cycle 0 is the cycle in which a request
// is first seen in IDLE. Samples are taken 1 time unit after each rising edge.
module tb_mem_access_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req, data_req, data_we;
    logic [15:0] fetch_addr, data_addr;
    logic [7:0]  data_wdata;

    // MEM_LAT=2 instance
    logic        fetch_gnt, fetch_done, data_gnt, data_done, mem_rd, mem_wr, busy;
    logic [7:0]  rdata, mem_wdata, mem_rdata;
    logic [15:0] mem_addr;
    // MEM_LAT=1 instance
    logic        fetch_gnt_l1, fetch_done_l1, data_gnt_l1, data_done_l1;
    logic        mem_rd_l1, mem_wr_l1, busy_l1;
    logic [7:0]  rdata_l1, mem_wdata_l1, mem_rdata_l1;
    logic [15:0] mem_addr_l1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_sched #(.ADDR_W(16), .DATA_W(8), .MEM_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_gnt(fetch_gnt), .fetch_done(fetch_done),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_gnt(data_gnt), .data_done(data_done),
        .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_access_sched #(.ADDR_W(16), .DATA_W(8), .MEM_LAT(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_gnt(fetch_gnt_l1), .fetch_done(fetch_done_l1),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_gnt(data_gnt_l1), .data_done(data_done_l1),
        .rdata(rdata_l1), .mem_addr(mem_addr_l1), .mem_wdata(mem_wdata_l1),
        .mem_rd(mem_rd_l1), .mem_wr(mem_wr_l1), .mem_rdata(mem_rdata_l1), .busy(busy_l1)
    );

    // ---------------- memory models ----------------
    function automatic logic [7:0] rd_val(input logic [15:0] a);
        case (a)
            16'h1234: return 8'hA5;
            16'h0100: return 8'h11;
            16'h0200: return 8'h22;
            16'h0010: return 8'h77;
            16'hBEEF: return 8'h99;
            default:  return a[7:0] ^ a[15:8];
        endcase
    endfunction

    // Data is presented only in the single valid cycle; otherwise 0xEE.
    logic       p2_v0, p2_v1, p1_v;
    logic [7:0] p2_d0, p2_d1, p1_d;
    always @(posedge clk) begin
        p2_v0 <= mem_rd;
        p2_d0 <= rd_val(mem_addr);
        p2_v1 <= p2_v0;
        p2_d1 <= p2_d0;
        p1_v  <= mem_rd_l1;
        p1_d  <= rd_val(mem_addr_l1);
    end
    assign mem_rdata    = p2_v1 ? p2_d1 : 8'hEE;
    assign mem_rdata_l1 = p1_v  ? p1_d  : 8'hEE;

    logic [15:0] wr_addr_seen = 16'h0;
    logic [7:0]  wr_data_seen = 8'h0;
    always @(posedge clk) begin
        if (mem_wr) begin
            wr_addr_seen <= mem_addr;
            wr_data_seen <= mem_wdata;
        end
    end

    // ---------------- clock/reset helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n      = 1'b0;
        fetch_req  = 1'b0;
        data_req   = 1'b0;
        data_we    = 1'b0;
        fetch_addr = 16'h0;
        data_addr  = 16'h0;
        data_wdata = 8'h0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fetch_req  = 1'($urandom_range(0, 1));
            data_req   = 1'($urandom_range(0, 1));
            data_we    = 1'($urandom_range(0, 1));
            fetch_addr = 16'($urandom_range(0, 65535));
            data_addr  = 16'($urandom_range(0, 65535));
            data_wdata = 8'($urandom_range(0, 255));
            tick();
            checks++;
            if ({fetch_gnt, fetch_done, data_gnt, data_done, rdata, mem_addr,
                 mem_wdata, mem_rd, mem_wr, busy} !== 39'h0) begin
                failures++;
                $display("FAIL reset_outputs i=%0d got busy=%0b rd=%0b wr=%0b addr=%h rdata=%h exp all 0",
                         i, busy, mem_rd, mem_wr, mem_addr, rdata);
            end
            checks++;
            if ({fetch_gnt_l1, fetch_done_l1, data_gnt_l1, data_done_l1, rdata_l1, mem_addr_l1,
                 mem_wdata_l1, mem_rd_l1, mem_wr_l1, busy_l1} !== 39'h0) begin
                failures++;
                $display("FAIL reset_outputs_l1 i=%0d got busy=%0b rd=%0b addr=%h exp all 0",
                         i, busy_l1, mem_rd_l1, mem_addr_l1);
            end
        end
        fetch_req = 1'b0;
        data_req  = 1'b0;
        data_we   = 1'b0;
        rst_n     = 1'b1;
        tick();
    endtask

    task automatic test_data_read();
        apply_reset();
        data_req  = 1'b1;
        data_we   = 1'b0;
        data_addr = 16'h1234;
        for (int c = 1; c <= 5; c++) begin
            tick();
            checks++;
            if (mem_rd !== (c == 1)) begin
                failures++;
                $display("FAIL rd_strobe c=%0d got=%0b exp=%0b", c, mem_rd, (c == 1));
            end
            if (c != 4) begin
                checks++;
                if (mem_addr !== ((c <= 3) ? 16'h1234 : 16'h0)) begin
                    failures++;
                    $display("FAIL rd_addr c=%0d got=%h exp=%h", c, mem_addr,
                             ((c <= 3) ? 16'h1234 : 16'h0));
                end
            end
            checks++;
            if (data_done !== (c == 4) || fetch_done !== 1'b0) begin
                failures++;
                $display("FAIL rd_done c=%0d got d=%0b f=%0b exp d=%0b f=0", c, data_done,
                         fetch_done, (c == 4));
            end
            checks++;
            if (data_gnt !== (c <= 4) || busy !== (c <= 4)) begin
                failures++;
                $display("FAIL rd_gnt_busy c=%0d got gnt=%0b busy=%0b exp=%0b", c, data_gnt,
                         busy, (c <= 4));
            end
            checks++;
            if (data_done_l1 !== (c == 3)) begin
                failures++;
                $display("FAIL rd_done_l1 c=%0d got=%0b exp=%0b", c, data_done_l1, (c == 3));
            end
            if (c == 3) begin
                checks++;
                if (rdata_l1 !== 8'hA5) begin
                    failures++;
                    $display("FAIL rd_data_l1 got=%h exp=a5", rdata_l1);
                end
            end
            if (c == 4) begin
                checks++;
                if (rdata !== 8'hA5) begin
                    failures++;
                    $display("FAIL rd_data got=%h exp=a5", rdata);
                end
                data_req = 1'b0;
            end
        end
    endtask

    // Runs straight after test_data_read so rdata already holds 0xA5.
    task automatic test_data_write();
        data_req   = 1'b1;
        data_we    = 1'b1;
        data_addr  = 16'h00FF;
        data_wdata = 8'h3C;
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++;
            if (mem_wr !== (c == 1) || mem_rd !== 1'b0) begin
                failures++;
                $display("FAIL wr_strobe c=%0d got wr=%0b rd=%0b exp wr=%0b rd=0", c, mem_wr,
                         mem_rd, (c == 1));
            end
            if (c == 1) begin
                checks++;
                if (mem_addr !== 16'h00FF || mem_wdata !== 8'h3C) begin
                    failures++;
                    $display("FAIL wr_bus got addr=%h wdata=%h exp 00ff/3c", mem_addr, mem_wdata);
                end
            end
            checks++;
            if (data_done !== (c == 2) || data_done_l1 !== (c == 2)) begin
                failures++;
                $display("FAIL wr_done c=%0d got=%0b/%0b exp=%0b", c, data_done, data_done_l1,
                         (c == 2));
            end
            checks++;
            if (rdata !== 8'hA5 || rdata_l1 !== 8'hA5) begin
                failures++;
                $display("FAIL wr_rdata_hold c=%0d got=%h/%h exp=a5", c, rdata, rdata_l1);
            end
            if (c == 2) begin
                data_req = 1'b0;
                data_we  = 1'b0;
            end
            if (c == 3) begin
                checks++;
                if (busy !== 1'b0 || mem_wdata !== 8'h0 || mem_addr !== 16'h0) begin
                    failures++;
                    $display("FAIL wr_idle got busy=%0b wdata=%h addr=%h exp 0", busy, mem_wdata,
                             mem_addr);
                end
            end
        end
        checks++;
        if (wr_addr_seen !== 16'h00FF || wr_data_seen !== 8'h3C) begin
            failures++;
            $display("FAIL wr_mem got addr=%h data=%h exp 00ff/3c", wr_addr_seen, wr_data_seen);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        fetch_req  = 1'b1;
        fetch_addr = 16'h0100;
        data_req   = 1'b1;
        data_we    = 1'b0;
        data_addr  = 16'h0200;
        for (int c = 1; c <= 20; c++) begin
            int   ph;
            logic f_own;
            tick();
            ph    = (c - 1) % 5;
            f_own = (((c - 1) / 5) % 2) == 0;
            checks++;
            if (fetch_gnt !== (f_own && ph <= 3) || data_gnt !== (!f_own && ph <= 3)) begin
                failures++;
                $display("FAIL rr_gnt c=%0d got f=%0b d=%0b exp f=%0b d=%0b", c, fetch_gnt,
                         data_gnt, (f_own && ph <= 3), (!f_own && ph <= 3));
            end
            checks++;
            if (fetch_done !== (f_own && ph == 3) || data_done !== (!f_own && ph == 3)) begin
                failures++;
                $display("FAIL rr_done c=%0d got f=%0b d=%0b exp f=%0b d=%0b", c, fetch_done,
                         data_done, (f_own && ph == 3), (!f_own && ph == 3));
            end
            checks++;
            if (mem_rd !== (ph == 0)) begin
                failures++;
                $display("FAIL rr_strobe c=%0d got=%0b exp=%0b", c, mem_rd, (ph == 0));
            end
            if (ph == 0) begin
                checks++;
                if (mem_addr !== (f_own ? 16'h0100 : 16'h0200)) begin
                    failures++;
                    $display("FAIL rr_addr c=%0d got=%h exp=%h", c, mem_addr,
                             (f_own ? 16'h0100 : 16'h0200));
                end
            end
            if (ph == 3) begin
                checks++;
                if (rdata !== (f_own ? 8'h11 : 8'h22)) begin
                    failures++;
                    $display("FAIL rr_rdata c=%0d got=%h exp=%h", c, rdata,
                             (f_own ? 8'h11 : 8'h22));
                end
            end
            if (c == 19) begin
                fetch_req = 1'b0;
                data_req  = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        fetch_req  = 1'b1;
        fetch_addr = 16'h0300;
        tick();  // cycle 1: ISSUE
        tick();  // cycle 2: WAIT
        checks++;
        if (fetch_gnt !== 1'b1 || busy !== 1'b1 || mem_addr !== 16'h0300) begin
            failures++;
            $display("FAIL abort_pre got gnt=%0b busy=%0b addr=%h exp 1/1/0300", fetch_gnt, busy,
                     mem_addr);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (fetch_gnt !== 1'b0 || busy !== 1'b0 || mem_rd !== 1'b0 || mem_wr !== 1'b0 ||
            mem_addr !== 16'h0) begin
            failures++;
            $display("FAIL abort_async got gnt=%0b busy=%0b rd=%0b addr=%h exp 0", fetch_gnt,
                     busy, mem_rd, mem_addr);
        end
        data_req  = 1'b1;
        data_we   = 1'b0;
        data_addr = 16'h0400;
        for (int c = 3; c <= 5; c++) begin
            tick();
            checks++;
            if (fetch_done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL abort_no_done c=%0d got done=%0b busy=%0b exp 0/0", c, fetch_done,
                         busy);
            end
        end
        rst_n = 1'b1;  // cycle 0 after release: both requests high
        for (int c = 1; c <= 6; c++) begin
            tick();
            checks++;
            if (fetch_gnt !== (c <= 4) || data_gnt !== (c == 6)) begin
                failures++;
                $display("FAIL abort_regrant c=%0d got f=%0b d=%0b exp f=%0b d=%0b", c,
                         fetch_gnt, data_gnt, (c <= 4), (c == 6));
            end
            checks++;
            if (fetch_done !== (c == 4)) begin
                failures++;
                $display("FAIL abort_fetch_done c=%0d got=%0b exp=%0b", c, fetch_done, (c == 4));
            end
            if (c == 1) begin
                checks++;
                if (mem_addr !== 16'h0300 || mem_rd !== 1'b1) begin
                    failures++;
                    $display("FAIL abort_reissue got addr=%h rd=%0b exp 0300/1", mem_addr, mem_rd);
                end
            end
            if (c == 4) begin
                checks++;
                if (rdata !== 8'h03) begin
                    failures++;
                    $display("FAIL abort_rdata got=%h exp=03", rdata);
                end
                fetch_req = 1'b0;
            end
        end
        data_req = 1'b0;
    endtask

    task automatic test_req_drop();
        apply_reset();
        data_req  = 1'b1;
        data_we   = 1'b0;
        data_addr = 16'h0010;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c <= 3) begin
                checks++;
                if (mem_addr !== 16'h0010) begin
                    failures++;
                    $display("FAIL drop_addr c=%0d got=%h exp=0010", c, mem_addr);
                end
            end
            if (c <= 2) begin
                checks++;
                if (mem_addr_l1 !== 16'h0010) begin
                    failures++;
                    $display("FAIL drop_addr_l1 c=%0d got=%h exp=0010", c, mem_addr_l1);
                end
            end
            checks++;
            if (data_done !== (c == 4) || data_gnt !== (c <= 4)) begin
                failures++;
                $display("FAIL drop_done c=%0d got done=%0b gnt=%0b exp %0b/%0b", c, data_done,
                         data_gnt, (c == 4), (c <= 4));
            end
            checks++;
            if (data_done_l1 !== (c == 3) || data_gnt_l1 !== (c <= 3)) begin
                failures++;
                $display("FAIL drop_done_l1 c=%0d got done=%0b gnt=%0b exp %0b/%0b", c,
                         data_done_l1, data_gnt_l1, (c == 3), (c <= 3));
            end
            if (c == 3) begin
                checks++;
                if (rdata_l1 !== 8'h77) begin
                    failures++;
                    $display("FAIL drop_rdata_l1 got=%h exp=77", rdata_l1);
                end
            end
            if (c == 4) begin
                checks++;
                if (rdata !== 8'h77) begin
                    failures++;
                    $display("FAIL drop_rdata got=%h exp=77", rdata);
                end
            end
            if (c == 5) begin
                checks++;
                if (busy !== 1'b0 || busy_l1 !== 1'b0) begin
                    failures++;
                    $display("FAIL drop_idle got busy=%0b/%0b exp 0/0", busy, busy_l1);
                end
            end
            if (c == 1) begin
                data_req  = 1'b0;
                data_addr = 16'hBEEF;
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n      = 1'b0;
        fetch_req  = 1'b0;
        data_req   = 1'b0;
        data_we    = 1'b0;
        fetch_addr = 16'h0;
        data_addr  = 16'h0;
        data_wdata = 8'h0;
        test_reset();
        test_data_read();
        test_data_write();
        test_round_robin();
        test_reset_mid_wait();
        test_req_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
